// File: rtl/tile_instr_sequencer.sv
// Per-tile instruction sequencer: small program memory loaded over a config port,
// replayed one word per unstalled cycle for a programmed number of passes.
module tile_instr_sequencer #(
  parameter int INSTR_W    = 64,
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int LOOP_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [INSTR_W-1:0] cfg_data,
  input  logic               start,
  input  logic [ADDR_W-1:0]  prog_end,
  input  logic [LOOP_W-1:0]  loop_count,
  input  logic               stall,
  input  logic               abort,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   imem_q [IMEM_DEPTH];
  logic [IMEM_DEPTH-1:0] entry_we;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    end_q, end_d;
  logic [LOOP_W-1:0]    rem_q, rem_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic [ADDR_W-1:0]    pc_inc;
  logic [ADDR_W-1:0]    prog_end_clamped;
  logic                 cfg_we;

  assign cfg_ready = (state_q == S_IDLE);
  assign cfg_we    = cfg_valid && cfg_ready;
  assign pc_inc    = pc_q + ADDR_W'(1);

  // Addresses that decode to no entry simply match no write enable, so they are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < IMEM_DEPTH; gi++) begin : g_we
      assign entry_we[gi] = cfg_we && (cfg_addr == ADDR_W'(gi));
    end
    if ((2 ** ADDR_W) > IMEM_DEPTH) begin : g_clamp
      assign prog_end_clamped = (prog_end > ADDR_W'(IMEM_DEPTH - 1)) ?
                                ADDR_W'(IMEM_DEPTH - 1) : prog_end;
    end else begin : g_noclamp
      assign prog_end_clamped = prog_end;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IMEM_DEPTH; i++) imem_q[i] <= '0;
    end else begin
      for (int i = 0; i < IMEM_DEPTH; i++) begin
        if (entry_we[i]) imem_q[i] <= cfg_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      end_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      end_q   <= end_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // A latched loop_count of 0 leaves rem_q at 0 forever, which never matches the last-pass test.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort) state_d = S_IDLE;
        else if (!stall && pc_q == end_q && rem_q == LOOP_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    end_d   = end_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          end_d   = prog_end_clamped;
          rem_d   = loop_count;
          pc_d    = '0;
          instr_d = imem_q[0];
          valid_d = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          instr_d = '0;
          valid_d = 1'b0;
          pc_d    = '0;
        end else if (!stall) begin
          if (pc_q != end_q) begin
            pc_d    = pc_inc;
            instr_d = imem_q[pc_inc];
          end else if (rem_q != LOOP_W'(1)) begin
            pc_d    = '0;
            instr_d = imem_q[0];
            if (rem_q != '0) rem_d = rem_q - LOOP_W'(1);
          end else begin
            pc_d    = '0;
            instr_d = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        instr_d = '0;
        valid_d = 1'b0;
        pc_d    = '0;
      end
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_RUN);
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_tile_instr_sequencer.sv
// Directed bench for tile_instr_sequencer: load, single/multi-pass runs, stall,
// abort, async reset and config/start interaction during a run.
module tb_tile_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_addr;
  logic [63:0] cfg_data;
  logic        start;
  logic [3:0]  prog_end;
  logic [7:0]  loop_count;
  logic        stall;
  logic        abort;
  logic [63:0] instruction;
  logic        instr_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  int total  = 0;
  int passed = 0;
  int vc, dc;
  logic [63:0] abc [3];

  always #5 clk = ~clk;

  tile_instr_sequencer dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .prog_end(prog_end),
    .loop_count(loop_count), .stall(stall), .abort(abort), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [63:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic launch(input logic [3:0] pe, input logic [7:0] lc);
    prog_end = pe; loop_count = lc; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    abc[0] = 64'hA; abc[1] = 64'hB; abc[2] = 64'hC;
    rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
    prog_end = '0; loop_count = '0; stall = 1'b0; abort = 1'b0;
    tick();
    check("rst_instr", instruction, 64'h0);
    check("rst_valid", {63'h0, instr_valid}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    rst = 1'b0;
    #1;
    check("rst_cfg_ready", {63'h0, cfg_ready}, 64'h1);

    $display("step: single pass 6,2");
    cfg_write(4'd0, 64'h6);
    cfg_write(4'd1, 64'h2);
    launch(4'd1, 8'd1);
    check("t2_i0", instruction, 64'h6);
    check("t2_v0", {63'h0, instr_valid}, 64'h1);
    check("t2_busy", {63'h0, busy}, 64'h1);
    check("t2_pc0", {60'h0, pc}, 64'h0);
    check("t2_cfg_ready_run", {63'h0, cfg_ready}, 64'h0);
    tick();
    check("t2_i1", instruction, 64'h2);
    check("t2_pc1", {60'h0, pc}, 64'h1);
    tick();
    check("t2_v_end", {63'h0, instr_valid}, 64'h0);
    check("t2_i_end", instruction, 64'h0);
    check("t2_done", {63'h0, done}, 64'h1);
    check("t2_busy_end", {63'h0, busy}, 64'h0);
    tick();
    check("t2_done_pulse", {63'h0, done}, 64'h0);
    check("t2_idle_ready", {63'h0, cfg_ready}, 64'h1);

    $display("step: three passes A,B,C");
    for (int i = 0; i < 3; i++) cfg_write(4'(i), abc[i]);
    launch(4'd2, 8'd3);
    vc = 0; dc = 0;
    for (int i = 0; i < 14; i++) begin
      if (instr_valid) begin
        check("t3_order", instruction, abc[vc % 3]);
        vc++;
      end
      if (done) dc++;
      tick();
    end
    check("t3_valid_cycles", 64'(vc), 64'd9);
    check("t3_done_count", 64'(dc), 64'd1);
    check("t3_busy_end", {63'h0, busy}, 64'h0);

    $display("step: stall at pc=1");
    launch(4'd2, 8'd1);
    check("t4_a", instruction, abc[0]);
    tick();
    check("t4_b", instruction, abc[1]);
    stall = 1'b1;
    tick();
    check("t4_hold1_i", instruction, abc[1]);
    check("t4_hold1_pc", {60'h0, pc}, 64'h1);
    check("t4_hold1_v", {63'h0, instr_valid}, 64'h1);
    tick();
    check("t4_hold2_i", instruction, abc[1]);
    check("t4_hold2_pc", {60'h0, pc}, 64'h1);
    stall = 1'b0;
    tick();
    check("t4_c", instruction, abc[2]);
    check("t4_c_pc", {60'h0, pc}, 64'h2);
    tick();
    check("t4_done", {63'h0, done}, 64'h1);
    check("t4_v_end", {63'h0, instr_valid}, 64'h0);
    tick();

    $display("step: async reset mid-run");
    launch(4'd2, 8'd0);
    tick();
    #3 rst = 1'b1;
    #1;
    check("t1_instr", instruction, 64'h0);
    check("t1_valid", {63'h0, instr_valid}, 64'h0);
    check("t1_busy", {63'h0, busy}, 64'h0);
    check("t1_done", {63'h0, done}, 64'h0);
    tick();
    rst = 1'b0;
    #1;
    check("t1_cfg_ready", {63'h0, cfg_ready}, 64'h1);
    launch(4'd0, 8'd1);
    check("t1_imem_zero", instruction, 64'h0);
    check("t1_imem_zero_v", {63'h0, instr_valid}, 64'h1);
    tick();
    check("t1_done_after", {63'h0, done}, 64'h1);
    tick();

    $display("step: endless run then abort");
    for (int i = 0; i < 3; i++) cfg_write(4'(i), abc[i]);
    launch(4'd2, 8'd0);
    dc = 0; vc = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dc++;
      if (instr_valid && instruction === abc[i % 3]) vc++;
      tick();
    end
    check("t5_stream", 64'(vc), 64'd20);
    abort = 1'b1; stall = 1'b1;
    tick();
    abort = 1'b0; stall = 1'b0;
    check("t5_valid", {63'h0, instr_valid}, 64'h0);
    check("t5_busy", {63'h0, busy}, 64'h0);
    check("t5_pc", {60'h0, pc}, 64'h0);
    check("t5_instr", instruction, 64'h0);
    for (int i = 0; i < 3; i++) begin
      if (done) dc++;
      tick();
    end
    check("t5_no_done", 64'(dc), 64'd0);

    $display("step: config and start during run");
    launch(4'd2, 8'd0);
    cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 64'hDEAD;
    start = 1'b1; prog_end = 4'd0; loop_count = 8'd1;
    #1;
    check("t6_cfg_ready", {63'h0, cfg_ready}, 64'h0);
    tick();
    check("t6_b", instruction, abc[1]);
    tick();
    check("t6_c", instruction, abc[2]);
    tick();
    check("t6_wrap_a", instruction, abc[0]);
    check("t6_wrap_pc", {60'h0, pc}, 64'h0);
    cfg_valid = 1'b0; start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    launch(4'd0, 8'd1);
    check("t6_imem0_kept", instruction, abc[0]);
    tick();
    check("t6_rerun_done", {63'h0, done}, 64'h1);
    tick();

    $display("step: config write and start on the same edge");
    cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 64'hD;
    launch(4'd0, 8'd2);
    cfg_valid = 1'b0;
    check("t7_old_word", instruction, abc[0]);
    tick();
    check("t7_new_word", instruction, 64'hD);
    tick();
    check("t7_done", {63'h0, done}, 64'h1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
